mux_serializer: RTL
===================

Name: mux_serializer

Overview:
Parallel-in, serial-out stage that drives the select input of an N-to-1 multiplexer from an internal counter. It captures an N-bit word on a valid/ready handshake, then presents one bit per enabled clock cycle on ser_out, along with the current select value. It feeds downstream serial consumers and reuses an N-to-1 mux internally for the bit selection.

Parameters:
N, 4, word width and number of mux inputs; N >= 2, not required to be a power of 2.
SEL_W, $clog2(N), width of the select counter; derived, not overridden.
MSB_FIRST, 0, 0 = emit data_reg[0] first; 1 = emit data_reg[N-1] first.

Ports:
clk  input  1  rising-edge clock
n_reset  input  1  asynchronous, active-low reset
en  input  1  shift enable; 0 stalls the serializer in SHIFT
load_valid  input  1  upstream word available
load_ready  output  1  serializer can accept a word this cycle
data_in  input  N  word to serialize
ser_out  output  1  current serial bit
ser_valid  output  1  ser_out is valid
sel  output  SEL_W  current mux select (bit index counter)
last  output  1  current bit is the final bit of the word

Behaviour:
- Reset (n_reset=0, async):
  - state=IDLE, data_reg=0, sel=0.
  - Outputs: ser_valid=0, ser_out=0, last=0, load_ready=1.
  - Takes effect immediately, mid-word included; a partial word is discarded.
- States: IDLE, SHIFT. The enum type lives in the package.
- IDLE:
  - load_ready=1, ser_valid=0, ser_out=0, last=0.
  - Edge with load_valid=1: data_reg<=data_in, sel<=0, state<=SHIFT.
- SHIFT, outputs:
  - ser_valid=1.
  - ser_out = data_reg[sel] when MSB_FIRST=0, else data_reg[N-1-sel]; combinational from registers via the mux sub-module.
  - last = (sel==N-1).
- SHIFT, edge with en=0: hold state, sel and data_reg; outputs unchanged.
- SHIFT, edge with en=1 and last=0: sel<=sel+1.
- SHIFT, edge with en=1 and last=1:
  - load_valid=1: data_reg<=data_in, sel<=0, remain SHIFT. Back-to-back words, no bubble.
  - load_valid=0: state<=IDLE, sel<=0.
- load_ready:
  - 1 in IDLE.
  - In SHIFT, load_ready = last & en.
  - Never 1 during a non-final bit, so data_reg cannot change mid-word.
- Latency:
  - First bit appears the cycle after the accepting edge.
  - A word occupies exactly N enabled cycles.
- Width rule: sel counts 0..N-1 and wraps to 0. Values >= N never occur; this matters when N is not a power of 2.
- data_in is ignored whenever load_ready=0.
- en is ignored in IDLE.

Decomposition:
- Package mux_serializer_pkg holds:
  - typedef enum logic {IDLE, SHIFT} ser_state_t;
  - the IDLE reset values.
- One sub-module, mux_n_behavioural: purely combinational N-to-1 mux (parameter N; ports y, d[N-1:0], s[SEL_W-1:0]).
  - Instantiated once with d=data_reg, s=sel, or N-1-sel when MSB_FIRST=1.
  - For N=4 it matches the team's 4-to-1 mux truth table.
- Everything else (state register, counter, handshake) stays in mux_serializer.

Test Plan:
- Reset then idle: hold n_reset=0 for 2 cycles, release, no load_valid → load_ready=1, ser_valid=0, sel=0, ser_out=0 for 5 cycles.
- Single word, N=4, MSB_FIRST=0, en=1: load 4'b0100 → over the next 4 cycles, sel=0,1,2,3 and ser_out=0,0,1,0; last=1 only at sel=3; then IDLE with ser_valid=0.
- Stall: load 4'b1011, drop en for 3 cycles while sel=1 → sel stays 1 and ser_out stays 1; resume gives 1,0,1 (full sequence 1,1,0,1).
- Back-to-back: hold load_valid=1 with 4'b0001 then 4'b1000 → serial stream 1,0,0,0,0,0,0,1 with no ser_valid gap; load_ready pulses high only on the last-bit cycle.
- MSB_FIRST=1, N=4: load 4'b0100 → ser_out=0,1,0,0.
- Async reset mid-word plus N=3: assert n_reset=0 mid-clock at sel=2 → outputs go to reset values before the next edge.
  - Then with N=3, load 3'b110 → sel=0,1,2 wraps to 0, ser_out=0,1,1.

Source files
------------

// File: rtl/mux_serializer_pkg.sv
// Shared types and reset values for the mux-driven parallel-to-serial stage.
package mux_serializer_pkg;

  // Two-state control: waiting for a word, or walking the select counter.
  typedef enum logic {IDLE, SHIFT} ser_state_t;

  // Values presented while idle and immediately after reset.
  localparam ser_state_t RST_STATE      = IDLE;
  localparam logic       RST_SER_OUT    = 1'b0;
  localparam logic       RST_SER_VALID  = 1'b0;
  localparam logic       RST_LAST       = 1'b0;
  localparam logic       RST_LOAD_READY = 1'b1;

endpackage

// File: rtl/mux_n_behavioural.sv
// Purely combinational N-to-1 multiplexer. Out-of-range selects (only possible when N is
// not a power of two) drive 0 rather than X.
module mux_n_behavioural #(
  parameter int unsigned N = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  output logic             y,
  input  logic [N-1:0]     d,
  input  logic [SEL_W-1:0] s
);

  // Compare against every legal index so unused select codes fall through to 0.
  always_comb begin
    y = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (s == SEL_W'(i)) y = d[i];
    end
  end

endmodule

// File: rtl/mux_serializer.sv
// Parallel-in, serial-out stage. A word is captured on a valid/ready handshake and then
// presented one bit per enabled cycle, the bit being picked by an N-to-1 mux whose select
// is the internal bit counter.
module mux_serializer
  import mux_serializer_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter bit MSB_FIRST = 1'b0,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [N-1:0]     data_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic [SEL_W-1:0] sel,
  output logic             last
);

  localparam logic [SEL_W-1:0] LastSel = SEL_W'(N - 1);

  ser_state_t       state_q, state_d;
  logic [N-1:0]     data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] mux_sel;
  logic             mux_y;
  logic             at_last;

  assign at_last = (sel_q == LastSel);

  // Reverse the bit index for MSB-first ordering; the counter itself always runs upward.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign mux_sel = LastSel - sel_q;
    end else begin : g_lsb_first
      assign mux_sel = sel_q;
    end
  endgenerate

  mux_n_behavioural #(
    .N (N)
  ) u_mux (
    .y (mux_y),
    .d (data_q),
    .s (mux_sel)
  );

  // State, word and counter registers; reset discards any partial word immediately.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= RST_STATE;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state: load from IDLE, advance on enable, reload or retire after the last bit.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          data_d  = data_in;
          sel_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          if (!at_last) begin
            sel_d = sel_q + 1'b1;
          end else if (load_valid) begin
            // Back-to-back word: no idle bubble between the two.
            data_d = data_in;
            sel_d  = '0;
          end else begin
            sel_d   = '0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // Outputs are decoded from registers only, except load_ready which also sees en.
  always_comb begin
    load_ready = RST_LOAD_READY;
    ser_valid  = RST_SER_VALID;
    ser_out    = RST_SER_OUT;
    last       = RST_LAST;
    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        ser_valid  = 1'b1;
        ser_out    = mux_y;
        last       = at_last;
        // Only open for a new word on the enabled final bit, so data_q never changes
        // mid-word.
        load_ready = at_last & en;
      end
    endcase
  end

  assign sel = sel_q;

endmodule
